psum_collector: RTL and testbench

- Sink at the bottom of each PE column. It is the receiver end of the PSUM_PACKET valid/ack chain that PEs drive through psum_out and psum_ack_in.
- Accepts finished, vertically accumulated psums and applies shift, saturation and optional ReLU.
- Packs four results per filter into one output word and pushes words through a small FIFO to the ofmap buffer over a valid/ready interface.
- Tracks row completion and reports done.

---
 rtl/psum_collector.sv | 185 ++++++++++++++++++
 tb/tb_psum_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// Column sink: quantizes finished psums, packs PACK results per filter into
// output words and streams them through a small FIFO to the ofmap buffer.
module psum_collector #(
    parameter  int FILTER_NUM = 4,
    parameter  int PACK       = 4,
    parameter  int OUT_W      = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int FIDX_W     = $clog2(FILTER_NUM),
    localparam int PSUM_W     = 12,
    localparam int PKT_W      = 1 + PSUM_W + FIDX_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [5:0]            i_row_len,
    input  logic [2:0]            i_shift,
    input  logic                  i_relu_en,
    input  logic [PKT_W-1:0]      i_psum_in,
    output logic                  o_psum_ack_out,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [PACK*OUT_W-1:0] o_out_data,
    output logic [FIDX_W-1:0]     o_out_filter_idx,
    output logic                  o_out_last,
    output logic                  o_busy,
    output logic                  o_row_done
);
    localparam int LCNT_W = $clog2(PACK);
    localparam int FPTR_W = $clog2(FIFO_DEPTH);
    localparam logic signed [PSUM_W-1:0] SAT_MAX = 12'sd127;
    localparam logic signed [PSUM_W-1:0] SAT_MIN = -12'sd128;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t                     r_state, w_next_state;
    logic [5:0]                 r_row_len;
    logic [2:0]                 r_shift;
    logic                       r_relu_en;
    logic [PACK*OUT_W-1:0]      r_lane     [FILTER_NUM];
    logic [LCNT_W-1:0]          r_lane_cnt [FILTER_NUM];
    logic [5:0]                 r_res_cnt  [FILTER_NUM];
    logic [PACK*OUT_W-1:0]      r_fifo_data [FIFO_DEPTH];
    logic [FIDX_W-1:0]          r_fifo_fidx [FIFO_DEPTH];
    logic                       r_fifo_last [FIFO_DEPTH];
    logic [FPTR_W-1:0]          r_wptr, r_rptr;
    logic [FPTR_W:0]            r_count;

    logic                       w_valid;
    logic signed [PSUM_W-1:0]   w_psum;
    logic signed [PSUM_W-1:0]   w_shifted;
    logic [FIDX_W-1:0]          w_fidx;
    logic [OUT_W-1:0]           w_q;
    logic [PACK*OUT_W-1:0]      w_lane_next;
    logic [5:0]                 w_res_next;
    logic                       w_ack, w_flush, w_last, w_pop;
    logic                       w_fifo_full, w_fifo_empty, w_all_done;

    assign w_valid      = i_psum_in[PKT_W-1];
    assign w_psum       = i_psum_in[PKT_W-2:FIDX_W];
    assign w_fidx       = i_psum_in[FIDX_W-1:0];
    assign w_shifted    = w_psum >>> r_shift;
    assign w_fifo_full  = (r_count == (FPTR_W+1)'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);

    // Acceptance ignores a same-cycle pop, so a full FIFO always stalls the PE.
    assign w_ack = w_valid && (r_state == COLLECT) && !w_fifo_full
                   && (r_res_cnt[w_fidx] < r_row_len);
    assign w_res_next = r_res_cnt[w_fidx] + 6'd1;
    assign w_last     = (w_res_next == r_row_len);
    assign w_flush    = w_ack && ((r_lane_cnt[w_fidx] == LCNT_W'(PACK-1)) || w_last);
    assign w_pop      = o_out_valid && i_out_ready;

    assign o_psum_ack_out   = w_ack;
    assign o_out_valid      = !w_fifo_empty;
    assign o_out_data       = r_fifo_data[r_rptr];
    assign o_out_filter_idx = r_fifo_fidx[r_rptr];
    assign o_out_last       = r_fifo_last[r_rptr];
    assign o_busy           = (r_state != IDLE);
    assign o_row_done       = (r_state == DONE);

    always_comb begin
        w_q = w_shifted[OUT_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_q = SAT_MAX[OUT_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_q = SAT_MIN[OUT_W-1:0];
        end
        if (r_relu_en && (w_shifted < 0)) begin
            w_q = '0;
        end
    end

    always_comb begin
        w_lane_next = r_lane[w_fidx];
        w_lane_next[r_lane_cnt[w_fidx]*OUT_W +: OUT_W] = w_q;
    end

    always_comb begin
        w_all_done = 1'b1;
        for (int f = 0; f < FILTER_NUM; f++) begin
            if (r_res_cnt[f] != r_row_len) begin
                w_all_done = 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = COLLECT;
            COLLECT: if (w_all_done) w_next_state = DRAIN;
            DRAIN:   if (w_fifo_empty) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row_len <= '0;
            r_shift   <= '0;
            r_relu_en <= 1'b0;
            for (int f = 0; f < FILTER_NUM; f++) begin
                r_lane[f]     <= '0;
                r_lane_cnt[f] <= '0;
                r_res_cnt[f]  <= '0;
            end
        end else if ((r_state == IDLE) && i_start) begin
            r_row_len <= i_row_len;
            r_shift   <= i_shift;
            r_relu_en <= i_relu_en;
            for (int f = 0; f < FILTER_NUM; f++) begin
                r_lane[f]     <= '0;
                r_lane_cnt[f] <= '0;
                r_res_cnt[f]  <= '0;
            end
        end else if (w_ack) begin
            r_res_cnt[w_fidx] <= w_res_next;
            if (w_flush) begin
                r_lane[w_fidx]     <= '0;
                r_lane_cnt[w_fidx] <= '0;
            end else begin
                r_lane[w_fidx]     <= w_lane_next;
                r_lane_cnt[w_fidx] <= r_lane_cnt[w_fidx] + LCNT_W'(1);
            end
        end
    end

    // A flushed word goes straight into the FIFO on the same edge as its ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_fidx[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            if (w_flush) begin
                r_fifo_data[r_wptr] <= w_lane_next;
                r_fifo_fidx[r_wptr] <= w_fidx;
                r_fifo_last[r_wptr] <= w_last;
                r_wptr              <= r_wptr + FPTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FPTR_W'(1);
            end
            if (w_flush && !w_pop) begin
                r_count <= r_count + (FPTR_W+1)'(1);
            end else if (!w_flush && w_pop) begin
                r_count <= r_count - (FPTR_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: quantization, packing, backpressure,
// filter gating and mid-row reset, with hand-computed expected words.
module tb_psum_collector;
    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [5:0]  i_row_len;
    logic [2:0]  i_shift;
    logic        i_relu_en;
    logic [14:0] i_psum_in;
    logic        o_psum_ack_out;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_data;
    logic [1:0]  o_out_filter_idx;
    logic        o_out_last;
    logic        o_busy;
    logic        o_row_done;

    int          checks = 0;
    int          passes = 0;
    int          doneCnt = 0;
    logic [34:0] words[$];
    bit          acked;
    int          ackCnt;

    psum_collector dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_row_len(i_row_len),
        .i_shift(i_shift), .i_relu_en(i_relu_en), .i_psum_in(i_psum_in),
        .o_psum_ack_out(o_psum_ack_out), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_filter_idx(o_out_filter_idx), .o_out_last(o_out_last),
        .o_busy(o_busy), .o_row_done(o_row_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Records every pop and row_done pulse just before the rising edge.
    always @(negedge i_clk) begin
        #4;
        if (!i_rst && o_out_valid && i_out_ready) begin
            words.push_back({o_out_data, o_out_filter_idx, o_out_last});
        end
        if (!i_rst && o_row_done) begin
            doneCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            passes++;
        end
    endtask

    function automatic logic [34:0] mkWord(input logic [31:0] d, input logic [1:0] f, input logic l);
        return {d, f, l};
    endfunction

    task automatic applyReset(input int n);
        i_rst = 1'b1;
        repeat (n) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [5:0] len, input logic [2:0] sh, input logic relu);
        i_row_len = len;
        i_shift   = sh;
        i_relu_en = relu;
        i_start   = 1'b1;
        @(negedge i_clk);
        i_start   = 1'b0;
    endtask

    task automatic sendPsum(input logic [1:0] f, input int p, input int budget, output bit ok);
        logic [11:0] pv;
        pv = 12'(p);
        i_psum_in = {1'b1, pv, f};
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (o_psum_ack_out) begin
                ok = 1'b1;
                @(negedge i_clk);
                break;
            end
            @(negedge i_clk);
        end
        if (ok) i_psum_in = '0;
    endtask

    task automatic waitWords(input int n, input int budget);
        for (int c = 0; c < budget && words.size() < n; c++) @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_row_len = '0; i_shift = '0;
        i_relu_en = 1'b0; i_out_ready = 1'b1;
        i_psum_in = {1'b1, 12'd5, 2'd0};

        // Reset held with a pending packet.
        repeat (2) @(negedge i_clk);
        #1;
        checkOutput("rst_ack",   o_psum_ack_out, 0);
        checkOutput("rst_valid", o_out_valid, 0);
        checkOutput("rst_busy",  o_busy, 0);
        checkOutput("rst_done",  o_row_done, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        sendPsum(2'd0, 5, 3, acked);
        checkOutput("idle_no_ack", acked, 0);
        i_psum_in = '0;

        // Basic row: four filters, four results each.
        words.delete(); doneCnt = 0;
        applyStimulus(6'd4, 3'd0, 1'b0);
        ackCnt = 0;
        for (int f = 0; f < 4; f++) begin
            for (int k = 1; k <= 4; k++) begin
                sendPsum(2'(f), k, 20, acked);
                if (acked) ackCnt++;
            end
        end
        checkOutput("basic_acks", ackCnt, 16);
        for (int c = 0; c < 50 && o_busy; c++) @(negedge i_clk);
        checkOutput("basic_idle", o_busy, 0);
        checkOutput("basic_nwords", words.size(), 4);
        for (int f = 0; f < 4 && f < words.size(); f++) begin
            checkOutput($sformatf("basic_w%0d", f), words[f], mkWord(32'h04030201, 2'(f), 1'b1));
        end
        checkOutput("basic_rowdone", doneCnt, 1);

        // Partial word, shift, saturation and ReLU on filter 2.
        words.delete(); doneCnt = 0;
        applyStimulus(6'd6, 3'd2, 1'b1);
        sendPsum(2'd2, 12'h7FF, 20, acked);
        sendPsum(2'd2, 12'h800, 20, acked);
        sendPsum(2'd2, 12, 20, acked);
        sendPsum(2'd2, -4, 20, acked);
        sendPsum(2'd2, 20, 20, acked);
        sendPsum(2'd2, 8, 20, acked);
        waitWords(2, 20);
        checkOutput("sat_nwords", words.size(), 2);
        if (words.size() >= 2) begin
            checkOutput("sat_w0", words[0], mkWord(32'h0003007F, 2'd2, 1'b0));
            checkOutput("sat_w1", words[1], mkWord(32'h00000205, 2'd2, 1'b1));
        end
        checkOutput("sat_busy", o_busy, 1);
        applyReset(1);

        // Backpressure: FIFO fills, PE is stalled, then drains in order.
        words.delete(); doneCnt = 0;
        i_out_ready = 1'b0;
        applyStimulus(6'd63, 3'd0, 1'b0);
        ackCnt = 0;
        for (int k = 1; k <= 16; k++) begin
            sendPsum(2'd0, k, 20, acked);
            if (acked) ackCnt++;
        end
        checkOutput("bp_acks", ackCnt, 16);
        sendPsum(2'd0, 17, 5, acked);
        checkOutput("bp_stall", acked, 0);
        checkOutput("bp_head", o_out_data, 32'h04030201);
        checkOutput("bp_valid", o_out_valid, 1);
        checkOutput("bp_noPop", words.size(), 0);
        i_out_ready = 1'b1;
        ackCnt = 0;
        for (int k = 17; k <= 20; k++) begin
            sendPsum(2'd0, k, 20, acked);
            if (acked) ackCnt++;
        end
        checkOutput("bp_resume", ackCnt, 4);
        waitWords(5, 50);
        repeat (3) @(negedge i_clk);
        checkOutput("bp_nwords", words.size(), 5);
        for (int w = 0; w < 5 && w < words.size(); w++) begin
            logic [31:0] d;
            d = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
            checkOutput($sformatf("bp_w%0d", w), words[w], mkWord(d, 2'd0, 1'b0));
        end
        applyReset(1);

        // Interleaved filters 0 and 3; filters 1 and 2 stay silent.
        words.delete(); doneCnt = 0;
        sendPsum(2'd0, 9, 3, acked);
        checkOutput("pre_start", acked, 0);
        i_psum_in = '0;
        applyStimulus(6'd2, 3'd0, 1'b0);
        sendPsum(2'd0, 5, 20, acked);
        sendPsum(2'd3, 6, 20, acked);
        sendPsum(2'd0, 7, 20, acked);
        sendPsum(2'd3, 8, 20, acked);
        repeat (10) @(negedge i_clk);
        checkOutput("il_nwords", words.size(), 2);
        if (words.size() >= 2) begin
            checkOutput("il_w0", words[0], mkWord(32'h00000705, 2'd0, 1'b1));
            checkOutput("il_w1", words[1], mkWord(32'h00000806, 2'd3, 1'b1));
        end
        checkOutput("il_busy", o_busy, 1);
        checkOutput("il_rowdone", doneCnt, 0);
        applyReset(1);

        // Mid-row reset drops partial data; a new row counts from scratch.
        words.delete(); doneCnt = 0;
        applyStimulus(6'd4, 3'd0, 1'b0);
        sendPsum(2'd1, 1, 20, acked);
        sendPsum(2'd1, 2, 20, acked);
        sendPsum(2'd1, 3, 20, acked);
        applyReset(1);
        #1;
        checkOutput("mr_valid", o_out_valid, 0);
        checkOutput("mr_busy", o_busy, 0);
        @(negedge i_clk);
        applyStimulus(6'd4, 3'd0, 1'b0);
        for (int k = 9; k <= 12; k++) sendPsum(2'd1, k, 20, acked);
        waitWords(1, 20);
        repeat (2) @(negedge i_clk);
        checkOutput("mr_nwords", words.size(), 1);
        if (words.size() >= 1) begin
            checkOutput("mr_w0", words[0], mkWord(32'h0C0B0A09, 2'd1, 1'b1));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
